// File: rtl/dac_frame_tx.sv
// Feedback-to-DAC transmitter: captures a 15-bit feedback word on a strobe edge,
// converts it to a 16-bit DAC code and shifts a 24-bit command+data frame, then pulses LDAC_n.
module dac_frame_tx #(
  parameter int         CLK_DIV    = 2,
  parameter logic [7:0] CMD        = 8'h30,
  parameter bit         OFFSET_BIN = 1'b1,
  parameter int         LDAC_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] pout,
  input  logic        oflow,
  input  logic        dac_strb,
  input  logic        fb_en,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_sdi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic [7:0]  missed_cnt,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_LDAC  = 2'd3;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW_W  = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LW_W-1:0]  LDAC_LAST = LW_W'(LDAC_W - 1);
  localparam logic [4:0]       BIT_LAST  = 5'd23;

  logic             strb_q, strb_d;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [4:0]       bit_q, bit_d;
  logic [23:0]      sh_q, sh_d;
  logic [LW_W-1:0]  lcnt_q, lcnt_d;
  logic [7:0]       missed_q, missed_d;
  logic [15:0]      frame_q, frame_d;
  logic             sclk_q, sclk_d;
  logic             sync_n_q, sync_n_d;
  logic             sdi_q, sdi_d;
  logic             ldac_n_q, ldac_n_d;
  logic             busy_q, busy_d;

  logic        trig;
  logic [15:0] code_raw;
  logic [15:0] code;

  assign trig = dac_strb & ~strb_q;

  // Disable forces mid-scale zero; overflow clamps to the signed extreme of the word's sign.
  always_comb begin
    if (!fb_en) begin
      code_raw = 16'h0000;
    end else if (oflow) begin
      code_raw = pout[14] ? 16'h8000 : 16'h7FFF;
    end else begin
      code_raw = {pout, 1'b0};
    end
    code = {code_raw[15] ^ OFFSET_BIN, code_raw[14:0]};
  end

  always_comb begin
    strb_d   = dac_strb;
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    lcnt_d   = lcnt_q;
    missed_d = missed_q;
    frame_d  = frame_q;

    if (trig && (state_q != S_IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_SHIFT;
          sh_d    = {CMD, code};
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_GAP;
            end else begin
              sh_d  = {sh_q[22:0], 1'b0};
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_LDAC;
        lcnt_d  = '0;
      end
      default: begin
        if (lcnt_q == LDAC_LAST) begin
          state_d = S_IDLE;
          frame_d = frame_q + 16'd1;
        end else begin
          lcnt_d = lcnt_q + LW_W'(1);
        end
      end
    endcase

    // Pin outputs are registered from the next state so they never glitch on decode.
    sclk_d   = (state_d == S_SHIFT) & phase_d;
    sync_n_d = (state_d != S_SHIFT);
    sdi_d    = (state_d == S_SHIFT) & sh_d[23];
    ldac_n_d = (state_d != S_LDAC);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q   <= 1'b0;
      state_q  <= S_IDLE;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      sh_q     <= '0;
      lcnt_q   <= '0;
      missed_q <= '0;
      frame_q  <= '0;
      sclk_q   <= 1'b0;
      sync_n_q <= 1'b1;
      sdi_q    <= 1'b0;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      strb_q   <= strb_d;
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      lcnt_q   <= lcnt_d;
      missed_q <= missed_d;
      frame_q  <= frame_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sdi_q    <= sdi_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_sdi    = sdi_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign missed_cnt = missed_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_dac_frame_tx.sv
// Scoreboard bench for dac_frame_tx: two instances (offset-binary and two's complement)
// share randomized stimulus; a timing-level model predicts accepted frames and drops.
module tb_dac_frame_tx;

  localparam int CLK_DIV   = 2;
  localparam int LDAC_W    = 2;
  localparam int SHIFT_LEN = 48 * CLK_DIV;
  localparam int BUSY_LEN  = SHIFT_LEN + 1 + LDAC_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] pout = '0;
  logic        oflow = 1'b0;
  logic        dac_strb = 1'b0;
  logic        fb_en = 1'b0;

  logic        sclk_w   [2];
  logic        sync_n_w [2];
  logic        sdi_w    [2];
  logic        ldac_n_w [2];
  logic        busy_w   [2];
  logic [7:0]  missed_w [2];
  logic [15:0] frame_w  [2];

  typedef struct {
    int v;
    int fcnt;
  } exp_t;

  exp_t exp_list[$];
  int   rd_idx[2];
  int   n_pass = 0;
  int   n_total = 0;

  logic rst_hit = 1'b0;
  logic strb_prev_m = 1'b0;
  int   cyc = 0;
  int   next_free = 0;
  int   missed_m = 0;
  int   accepted_m = 0;

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Signed value the DAC should represent, before any offset-binary mapping.
  function automatic int ref_v(logic [14:0] p, logic of, logic en);
    if (!en) return 0;
    if (of) return p[14] ? -32768 : 32767;
    return 2 * int'($signed(p));
  endfunction

  // Reference model: a trigger is accepted only if the previous accepted frame's
  // busy window (plus its return-to-idle cycle) has fully elapsed.
  always @(posedge clk) begin
    rst_hit <= rst;
    cyc     <= cyc + 1;
    if (rst) begin
      strb_prev_m <= 1'b0;
      next_free   <= 0;
      missed_m    <= 0;
      accepted_m  <= 0;
    end else begin
      strb_prev_m <= dac_strb;
      if (dac_strb && !strb_prev_m) begin
        if (cyc >= next_free) begin
          exp_list.push_back('{v: ref_v(pout, oflow, fb_en), fcnt: accepted_m + 1});
          next_free  <= cyc + BUSY_LEN + 1;
          accepted_m <= accepted_m + 1;
        end else if (missed_m < 255) begin
          missed_m <= missed_m + 1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int OFS = (gi == 0) ? 32768 : 0;

    dac_frame_tx #(
      .CLK_DIV   (CLK_DIV),
      .CMD       (8'h30),
      .OFFSET_BIN(gi == 0 ? 1'b1 : 1'b0),
      .LDAC_W    (LDAC_W)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .pout      (pout),
      .oflow     (oflow),
      .dac_strb  (dac_strb),
      .fb_en     (fb_en),
      .dac_sclk  (sclk_w[gi]),
      .dac_sync_n(sync_n_w[gi]),
      .dac_sdi   (sdi_w[gi]),
      .dac_ldac_n(ldac_n_w[gi]),
      .busy      (busy_w[gi]),
      .missed_cnt(missed_w[gi]),
      .frame_cnt (frame_w[gi])
    );

    initial begin : mon
      logic        sclk_p, sync_p, sdi_p, ldac_p, busy_p;
      logic [23:0] bits;
      logic [15:0] exp_code;
      int          nbits, sync_low, ldac_low, busy_len, sync_rise_cyc, mcyc, hold_err;
      exp_t        e;
      sclk_p = 1'b0; sync_p = 1'b1; sdi_p = 1'b0; ldac_p = 1'b1; busy_p = 1'b0;
      bits = '0; nbits = 0; sync_low = 0; ldac_low = 0; busy_len = 0;
      sync_rise_cyc = 0; mcyc = 0; hold_err = 0;
      forever begin
        @(negedge clk);
        mcyc++;
        if (rst_hit) begin
          chk($sformatf("reset_idle_dut%0d", gi),
              {sclk_w[gi], sync_n_w[gi], sdi_w[gi], ldac_n_w[gi], busy_w[gi], missed_w[gi], frame_w[gi]},
              {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0});
          rd_idx[gi] = exp_list.size();
          sclk_p = 1'b0; sync_p = 1'b1; sdi_p = 1'b0; ldac_p = 1'b1; busy_p = 1'b0;
        end else begin
          if (busy_w[gi] && !busy_p) begin
            bits = '0; nbits = 0; sync_low = 0; ldac_low = 0; busy_len = 0; hold_err = 0;
          end
          if (busy_w[gi]) busy_len++;
          if (!sync_n_w[gi]) sync_low++;
          if (!ldac_n_w[gi]) ldac_low++;
          if (!sync_n_w[gi] && sclk_w[gi] && !sclk_p) begin
            bits = {bits[22:0], sdi_w[gi]};
            nbits++;
          end
          if (sclk_w[gi] && sclk_p && (sdi_w[gi] !== sdi_p)) hold_err++;
          if (sync_n_w[gi] && !sync_p) begin
            sync_rise_cyc = mcyc;
            chk($sformatf("gap_pins_dut%0d", gi), {sclk_w[gi], ldac_n_w[gi]}, 2'b01);
          end
          if (!ldac_n_w[gi] && ldac_p) begin
            chk($sformatf("gap_len_dut%0d", gi), mcyc - sync_rise_cyc, 1);
          end
          if (!busy_w[gi] && busy_p) begin
            if (rd_idx[gi] < exp_list.size()) begin
              e = exp_list[rd_idx[gi]];
              rd_idx[gi]++;
              exp_code = 16'(e.v + OFS);
              $display("dut%0d frame %0d: sent %h expected %h", gi, e.fcnt, bits, {8'h30, exp_code});
              chk($sformatf("frame_bits_dut%0d", gi), bits, {8'h30, exp_code});
              chk($sformatf("sclk_rises_dut%0d", gi), nbits, 24);
              chk($sformatf("sync_low_dut%0d", gi), sync_low, SHIFT_LEN);
              chk($sformatf("ldac_low_dut%0d", gi), ldac_low, LDAC_W);
              chk($sformatf("busy_len_dut%0d", gi), busy_len, BUSY_LEN);
              chk($sformatf("frame_cnt_dut%0d", gi), frame_w[gi], e.fcnt & 32'hFFFF);
              chk($sformatf("sdi_stable_dut%0d", gi), hold_err, 0);
            end else begin
              chk($sformatf("unexpected_frame_dut%0d", gi), rd_idx[gi], exp_list.size());
            end
          end
          sclk_p = sclk_w[gi]; sync_p = sync_n_w[gi]; sdi_p = sdi_w[gi];
          ldac_p = ldac_n_w[gi]; busy_p = busy_w[gi];
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(logic [14:0] p, logic of, logic en, int hold);
    pout = p; oflow = of; fb_en = en; dac_strb = 1'b1;
    tick(hold);
    dac_strb = 1'b0;
    pout = 15'($urandom); oflow = 1'($urandom); fb_en = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 1000) begin
      tick(1);
      n++;
    end
    chk("idle_within_bound", 32'(n < 1000), 32'd1);
    tick(3);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic chk_counters(string tag);
    chk({tag, "_missed_dut0"}, missed_w[0], missed_m);
    chk({tag, "_missed_dut1"}, missed_w[1], missed_m);
    chk({tag, "_frames_dut0"}, frame_w[0], accepted_m);
    chk({tag, "_frames_dut1"}, frame_w[1], accepted_m);
  endtask

  initial begin
    do_reset(3);

    strobe(15'h0123, 1'b0, 1'b1, 1); wait_idle();
    strobe(15'h7FFF, 1'b0, 1'b1, 1); wait_idle();
    strobe({1'b0, 14'($urandom)}, 1'b1, 1'b1, 1); wait_idle();
    strobe({1'b1, 14'($urandom)}, 1'b1, 1'b1, 1); wait_idle();
    strobe(15'($urandom), 1'($urandom), 1'b0, 1); wait_idle();
    chk_counters("directed");

    for (int i = 0; i < 25; i++) begin
      strobe(15'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
             int'($urandom_range(1, 4)));
      tick(int'($urandom_range(0, BUSY_LEN + 10)));
    end
    wait_idle();
    chk_counters("random");

    do_reset(1);
    strobe(15'h1555, 1'b0, 1'b1, 1);
    tick(19);
    strobe(15'h0AAA, 1'b0, 1'b1, 1);
    wait_idle();
    chk_counters("overlap");

    for (int i = 0; i < 300; i++) begin
      strobe(15'($urandom), 1'b0, 1'b1, 1);
      tick(1);
    end
    wait_idle();
    chk_counters("saturate");

    strobe(15'($urandom), 1'b0, 1'b1, 10); wait_idle();
    chk_counters("held");

    strobe(15'h2AAA, 1'b0, 1'b1, 1);
    tick(40);
    do_reset(1);
    strobe(15'($urandom), 1'($urandom), 1'b1, 1); wait_idle();
    chk_counters("post_reset");

    chk("drained_dut0", rd_idx[0], exp_list.size());
    chk("drained_dut1", rd_idx[1], exp_list.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_frame_tx.md
Name: dac_frame_tx

Overview:
- Transmit side of the feedback-to-DAC path.
- Captures the 15-bit signed feedback word from the feedback calculation stage on each rising edge of its DAC strobe.
- Converts the word to a 16-bit DAC code, saturating on overflow, and shifts it MSB-first as a 24-bit serial frame (8-bit command + 16-bit data) to an external SPI-style DAC, then pulses LDAC_n.
- Sits between the feedback calculation stage and the board DAC pins.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- CMD, 8'h30, command byte sent in frame bits [23:16].
- OFFSET_BIN, 1, 1 = offset-binary DAC code (invert MSB); 0 = two's complement.
- LDAC_W, 2, LDAC_n low-pulse width in clk cycles (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- pout  in  15  signed feedback word.
- oflow  in  1  overflow flag aligned with pout.
- dac_strb  in  1  frame trigger; rising edge starts a frame.
- fb_en  in  1  feedback enable, sampled at capture.
- dac_sclk  out  1  serial clock, idle low.
- dac_sync_n  out  1  frame select, active low.
- dac_sdi  out  1  serial data, MSB first.
- dac_ldac_n  out  1  load pulse, active low.
- busy  out  1  high from capture until the LDAC pulse ends.
- missed_cnt  out  8  count of triggers dropped while busy; saturates at 255.
- frame_cnt  out  16  count of completed frames; wraps.

Behaviour:
- Reset: all outputs and state return to these values on the cycle after rst is sampled high, including mid-frame:
  - dac_sclk=0, dac_sync_n=1, dac_sdi=0, dac_ldac_n=1, busy=0, missed_cnt=0, frame_cnt=0.
  - FSM=IDLE; edge detector history cleared to 0.
- Trigger:
  - trig = dac_strb & ~dac_strb_d, with dac_strb_d registered.
  - A multi-cycle high level gives exactly one trigger.
- Capture: if trig is seen in IDLE at cycle T, then at T+1 the block latches data16 and the FSM moves to SHIFT.
  - data16 rule, first matching case wins:
    - fb_en=0: 16'h0000.
    - oflow=1: pout[14] ? 16'h8000 : 16'h7FFF.
    - otherwise: {pout, 1'b0}.
  - If OFFSET_BIN=1, data16[15] is inverted.
  - frame = {CMD, data16}.
- FSM states: IDLE -> SHIFT -> GAP -> LDAC -> IDLE.
  - SHIFT:
    - dac_sync_n=0 from T+1.
    - Bit k (23 down to 0) is driven on dac_sdi for 2*CLK_DIV cycles: dac_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - The DAC samples on the rising SCLK edge.
    - dac_sdi changes only while dac_sclk is low.
  - GAP: after bit 0's high phase, one cycle with dac_sclk=0 and dac_sync_n=1.
  - LDAC: dac_ldac_n=0 for LDAC_W cycles, then IDLE; frame_cnt increments on exit.
  - busy=1 in SHIFT, GAP and LDAC.
  - Total busy time: 48*CLK_DIV + 1 + LDAC_W cycles.
- Trigger while busy: the frame in progress is unaffected. missed_cnt increments (saturating at 255) and the trigger is not queued.
- Trigger on the same cycle the FSM returns to IDLE: it is counted as missed. Triggers are accepted only while in IDLE.
- pout, oflow and fb_en are ignored except at capture.
- frame_cnt wraps from 16'hFFFF to 0.

Test Plan:
- Basic frame: CLK_DIV=2, fb_en=1, pout=15'h0123, oflow=0, one strobe.
  - Required: 24 SCLK rising edges, sampled bits = 24'h308246, sync_n low for 96 cycles.
  - Then one gap cycle, then ldac_n low 2 cycles; frame_cnt=1.
- Negative value: pout=15'h7FFF (-1) -> data 16'h7FFE, frame 24'h307FFE. With OFFSET_BIN=0 -> 24'h30FFFE.
- Saturation and enable:
  - oflow=1, pout[14]=0 -> data 16'hFFFF.
  - oflow=1, pout[14]=1 -> 16'h0000.
  - fb_en=0 with any pout -> 16'h8000.
- Overlap: second strobe 20 cycles after the first -> first frame is bit-exact, no second frame, missed_cnt=1. Then 300 extra overlapping strobes -> missed_cnt holds at 255.
- Held strobe: dac_strb high for 10 cycles -> exactly one frame.
- Mid-frame reset: rst asserted at bit 10 -> next cycle sync_n=1, sclk=0, ldac_n=1, busy=0, counters=0. A strobe after reset sends a complete, correct frame.
